// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; pointers carry an extra wrap MSB.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports: clock/reset_n, push/push_dat, pop, flush (empties, wins over push),
//        head_dat (oldest entry), full, empty, count (occupancy).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    fetch_entry_t mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    // Same slot index but opposite lap bit means the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push-while-full is legal then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order word requests, buffers PC-tagged words for decode.
// Latency: response -> out_valid one cycle later; first request the cycle reset_n deasserts.
// Backpressure: FIFO occupancy + outstanding requests capped at DEPTH, so responses never overflow.
//
// Ports: clock, reset_n (async, active-low);
//        imem_req_valid/ready/addr  word fetch request (addr held while stalled);
//        imem_rsp_valid/data        in-order response, one per accepted request;
//        redirect_valid/pc          flush and restart fetch at redirect_pc & ~3;
//        out_valid/ready/inst/pc    head entry to the decoder.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [XLEN-1:0]       out_pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_ONE = 1;
    localparam logic [CW:0]     DEPTH_W = DEPTH[CW:0];
    localparam logic [XLEN-1:0] PC_STEP = 4;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_nxt;
    logic [CW-1:0]   occupancy;
    logic            req_acc;
    logic            rsp_push;
    logic            out_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_dat;
    fetch_entry_t    head_dat;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit check: every outstanding request already owns a FIFO slot.
    // reset_n gates the request so it drops the moment reset asserts.
    assign imem_req_valid = reset_n && !redirect_valid &&
                            (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_acc        = imem_req_valid && imem_req_ready;

    // Responses while discarding, or in a redirect cycle, belong to the old stream.
    assign rsp_push = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign out_pop  = out_valid && out_ready;

    assign push_dat.pc   = resp_pc;
    assign push_dat.inst = imem_rsp_data;

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_acc)        outstanding_nxt = outstanding_nxt + CNT_ONE;
        if (imem_rsp_valid) outstanding_nxt = outstanding_nxt - CNT_ONE;

        // Everything still in flight after a redirect is stale, including
        // responses already owed to an earlier, undrained redirect.
        discard_nxt = discard;
        if (redirect_valid) begin
            discard_nxt = outstanding_nxt;
        end else if (imem_rsp_valid && (discard != '0)) begin
            discard_nxt = discard - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (req_acc) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end

            // resp_pc only follows kept responses: after a redirect the first
            // kept response is always the one requested at the new target.
            if (redirect_valid) begin
                resp_pc <= redirect_target;
            end else if (rsp_push) begin
                resp_pc <= resp_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (rsp_push),
        .push_dat (push_dat),
        .pop      (out_pop),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (occupancy)
    );

    assign out_valid = !fifo_empty;
    // Zero the payload when nothing is valid so idle outputs are deterministic.
    assign out_inst  = fifo_empty ? '0 : head_dat.inst;
    assign out_pc    = fifo_empty ? '0 : head_dat.pc;

endmodule
